// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two data-memory requesters and dmem_arbiter.
// Port 0 is the core load/store unit and port 1 is the debug/DMA loader.
interface dmem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we0;
    logic        req_we1;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [3:0]  req_be0;
    logic [3:0]  req_be1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_we0, req_we1, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_be0, req_be1, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we0, req_we1, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_be0, req_be1, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the data memory, with byte-enable merge and held response.
// Optional macro DMEM_ADDR_CHECK_EN: out-of-range word addresses are acked with rsp_err and never written.
module dmem_arbiter #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arbiter_if.slave bus,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (MEM_DEPTH < 1 || MEM_DEPTH > 1073741824) begin : g_bad_depth
        $error("dmem_arbiter: MEM_DEPTH out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        rsp_done;
    logic        in_range;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic [31:0] merged;
    logic [31:0] addr_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_valid_q;
    logic [1:0]  req_ready;

    // With both ports valid, the port that did not win last time goes next.
    always_comb begin
        grant = bus.req_valid[1];
        if (&bus.req_valid) begin
            grant = ~last_grant;
        end
    end

    always_comb begin
        sel_we    = grant ? bus.req_we1    : bus.req_we0;
        sel_addr  = grant ? bus.req_addr1  : bus.req_addr0;
        sel_wdata = grant ? bus.req_wdata1 : bus.req_wdata0;
        sel_be    = grant ? bus.req_be1    : bus.req_be0;
    end

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (sel_be[i]) begin
                merged[8*i +: 8] = sel_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [30:0] DEPTH_W = 31'(MEM_DEPTH);
    assign in_range = ({1'b0, sel_addr[31:2]} < DEPTH_W);
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        unique case (state)
            IDLE: begin
                mem_addr = sel_addr;
                if (|bus.req_valid) begin
                    accept            = 1'b1;
                    req_ready[grant]  = 1'b1;
                    mem_we            = sel_we & (|sel_be) & in_range;
                    state_next        = RESP;
                end
            end
            RESP: begin
                // Only the owner of the pending response can retire it.
                if (bus.rsp_ready[last_grant]) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            last_grant  <= 1'b1;
            addr_q      <= '0;
        end else if (accept) begin
            rsp_valid_q <= grant ? 2'b10 : 2'b01;
            rsp_rdata_q <= in_range ? mem_rdata : '0;
            last_grant  <= grant;
            addr_q      <= sel_addr;
        end else if (rsp_done) begin
            rsp_valid_q <= 2'b00;
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    logic rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= ~in_range;
        end else if (rsp_done) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign mem_wdata     = merged;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-port transaction table followed by
// hand-written sequences for arbitration, response hold, reset mid-response and the range check.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        load;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_DEPTH(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, synchronous write, word indexed.
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h0000_0A0A;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[8]  <= 32'hAABB_CCDD;
            mem[9]  <= 32'h0102_0304;
            mem[10] <= 32'h0000_0000;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_mem_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            bus.req_we0 = we; bus.req_addr0 = a; bus.req_wdata0 = d; bus.req_be0 = be;
        end else begin
            bus.req_we1 = we; bus.req_addr1 = a; bus.req_wdata1 = d; bus.req_be1 = be;
        end
    endtask

    initial begin
        logic [1:0] oh;
        int         g;

        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 32'h20, 32'h1122_3344, 4'h5, 1'b1, 32'hAA22_CC44, 32'hAABB_CCDD};
        vecs[2] = '{0, 1'b0, 32'h20, 32'h0,         4'hF, 1'b0, 32'h0,         32'hAA22_CC44};
        vecs[3] = '{0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0102_0304, 32'h0102_0304};
        vecs[4] = '{1, 1'b0, 32'h24, 32'h0,         4'hF, 1'b0, 32'h0,         32'h0102_0304};
        vecs[5] = '{0, 1'b1, 32'h2B, 32'hCAFE_F00D, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[6] = '{1, 1'b0, 32'h28, 32'h0,         4'hF, 1'b0, 32'h0,         32'hCAFE_F00D};
        vecs[7] = '{1, 1'b1, 32'h10, 32'h5A00_0000, 4'h8, 1'b1, 32'h5AAD_BEEF, 32'hDEAD_BEEF};
        vecs[8] = '{0, 1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'h0,         32'h5AAD_BEEF};

        rst = 1'b1;
        load = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        set_port(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_port(1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        tick;
        rst = 1'b0;
        load = 1'b0;
        #1;
        chk("reset rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("reset req_ready", {30'h0, bus.req_ready}, 32'h0);
        tick;

        // Single-port transactions, one at a time.
        for (int i = 0; i < 9; i++) begin
            oh = (vecs[i].port == 0) ? 2'b01 : 2'b10;
            set_port(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            set_port(1 - vecs[i].port, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);
            bus.req_valid = oh;
            #1;
            chk($sformatf("vec%0d req_ready", i), {30'h0, bus.req_ready}, {30'h0, oh});
            chk($sformatf("vec%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].exp_mem_we});
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
            if (vecs[i].we) chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            tick;
            bus.req_valid = 2'b00;
            chk($sformatf("vec%0d rsp_valid", i), {30'h0, bus.rsp_valid}, {30'h0, oh});
            chk($sformatf("vec%0d rsp_rdata", i), bus.rsp_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d rsp_err", i), {31'h0, bus.rsp_err}, 32'h0);
            chk($sformatf("vec%0d resp req_ready", i), {30'h0, bus.req_ready}, 32'h0);
            bus.rsp_ready = 2'b11;
            tick;
            bus.rsp_ready = 2'b00;
            chk($sformatf("vec%0d rsp_clear", i), {30'h0, bus.rsp_valid}, 32'h0);
        end
        chk("mem[4] after", mem[4], 32'h5AAD_BEEF);
        chk("mem[8] after", mem[8], 32'hAA22_CC44);
        chk("mem[9] be0 untouched", mem[9], 32'h0102_0304);
        chk("mem[10] after", mem[10], 32'hCAFE_F00D);

        // Both ports valid continuously: grants alternate starting with the port not served last.
        g = 1 - vecs[8].port;
        set_port(0, 1'b0, 32'h10, 32'h0, 4'hF);
        set_port(1, 1'b0, 32'h20, 32'h0, 4'hF);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            oh = (g == 0) ? 2'b01 : 2'b10;
            #1;
            chk($sformatf("alt%0d req_ready", k), {30'h0, bus.req_ready}, {30'h0, oh});
            tick;
            chk($sformatf("alt%0d rsp_valid", k), {30'h0, bus.rsp_valid}, {30'h0, oh});
            chk($sformatf("alt%0d rsp_rdata", k), bus.rsp_rdata,
                (g == 0) ? 32'h5AAD_BEEF : 32'hAA22_CC44);
            chk($sformatf("alt%0d resp req_ready", k), {30'h0, bus.req_ready}, 32'h0);
            tick;
            g = 1 - g;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        tick;

        // Response held for 5 cycles while the other port waits and raises a stray rsp_ready.
        set_port(0, 1'b0, 32'h24, 32'h0, 4'hF);
        set_port(1, 1'b0, 32'h28, 32'h0, 4'hF);
        bus.req_valid = 2'b01;
        #1;
        chk("hold accept", {30'h0, bus.req_ready}, 32'h1);
        tick;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold%0d rsp_valid", k), {30'h0, bus.rsp_valid}, 32'h1);
            chk($sformatf("hold%0d rsp_rdata", k), bus.rsp_rdata, 32'h0102_0304);
            chk($sformatf("hold%0d req_ready", k), {30'h0, bus.req_ready}, 32'h0);
            chk($sformatf("hold%0d mem_we", k), {31'h0, mem_we}, 32'h0);
            tick;
        end
        bus.rsp_ready = 2'b01;
        tick;
        bus.rsp_ready = 2'b00;
        #1;
        chk("waiter granted", {30'h0, bus.req_ready}, 32'h2);
        chk("waiter mem_addr", mem_addr, 32'h28);
        tick;
        bus.req_valid = 2'b00;
        chk("waiter rsp_valid", {30'h0, bus.rsp_valid}, 32'h2);
        chk("waiter rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        bus.rsp_ready = 2'b11;
        tick;
        bus.rsp_ready = 2'b00;

        // Reset while a write response is pending: response dropped, write kept, port 0 wins next.
        set_port(1, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
        bus.req_valid = 2'b10;
        #1;
        chk("rstwr mem_we", {31'h0, mem_we}, 32'h1);
        tick;
        bus.req_valid = 2'b00;
        chk("rstwr rsp_valid", {30'h0, bus.rsp_valid}, 32'h2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst mid rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
        chk("rst mid rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst mid req_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("rst mid write kept", mem[12], 32'h1234_5678);
        set_port(0, 1'b0, 32'h10, 32'h0, 4'hF);
        set_port(1, 1'b0, 32'h20, 32'h0, 4'hF);
        bus.req_valid = 2'b11;
        #1;
        chk("post rst grant", {30'h0, bus.req_ready}, 32'h1);
        tick;
        bus.req_valid = 2'b00;
        chk("post rst rsp_valid", {30'h0, bus.rsp_valid}, 32'h1);
        chk("post rst rsp_rdata", bus.rsp_rdata, 32'h5AAD_BEEF);
        bus.rsp_ready = 2'b11;
        tick;
        bus.rsp_ready = 2'b00;

        // Write to byte address 0x1000, one word past a 1024-word memory.
        set_port(0, 1'b1, 32'h1000, 32'hBADB_AD00, 4'hF);
        bus.req_valid = 2'b01;
        #1;
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor mem_we", {31'h0, mem_we}, 32'h0);
`else
        chk("wrap mem_we", {31'h0, mem_we}, 32'h1);
`endif
        tick;
        bus.req_valid = 2'b00;
        chk("oor rsp_valid", {30'h0, bus.rsp_valid}, 32'h1);
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor rsp_err", {31'h0, bus.rsp_err}, 32'h1);
        chk("oor rsp_rdata", bus.rsp_rdata, 32'h0);
`else
        chk("wrap rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("wrap rsp_rdata", bus.rsp_rdata, 32'h0000_0A0A);
`endif
        bus.rsp_ready = 2'b01;
        tick;
        bus.rsp_ready = 2'b00;
        chk("oor rsp_err clear", {31'h0, bus.rsp_err}, 32'h0);
        chk("oor rsp_valid clear", {30'h0, bus.rsp_valid}, 32'h0);
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor mem[0] unchanged", mem[0], 32'h0000_0A0A);
`else
        chk("wrap mem[0] written", mem[0], 32'hBADB_AD00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
